// File: rtl/hex_word_entry.sv
// Hex word entry: debounced keys build a W-bit word nibble by nibble,
// then hand it off on a valid/ready port.
module hex_word_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DIGITS          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   nibble_in,
    input  logic                         key_push_n,
    input  logic                         key_clear_n,
    input  logic                         key_commit_n,
    output logic [4*DIGITS-1:0]          entry_word,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [4*DIGITS-1:0]          data_out,
    output logic                         word_valid,
    input  logic                         word_ready
);

    localparam int W  = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(DIGITS);

    typedef enum logic {ENTRY, HOLD} state_t;

    state_t        state;
    logic [2:0]    raw_n;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    evt;
    logic [CW-1:0] cnt [3];
    logic          push_ev;
    logic          clr_ev;
    logic          cmt_ev;

    assign raw_n   = {key_commit_n, key_clear_n, key_push_n};
    assign push_ev = evt[0];
    assign clr_ev  = evt[1];
    assign cmt_ev  = evt[2];

    // Stable flips on the cycle the counter would reach DEBOUNCE_CYCLES,
    // and the press pulse is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            evt    <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                evt[k] <= 1'b0;
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                    evt[k]    <= stable[k];
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENTRY;
            entry_word  <= '0;
            digit_count <= '0;
            data_out    <= '0;
            word_valid  <= 1'b0;
        end else begin
            if (clr_ev) begin
                entry_word  <= '0;
                digit_count <= '0;
            end else if (cmt_ev) begin
                if (state == ENTRY) begin
                    data_out    <= entry_word;
                    word_valid  <= 1'b1;
                    entry_word  <= '0;
                    digit_count <= '0;
                    state       <= HOLD;
                end
            end else if (push_ev) begin
                entry_word <= (entry_word << 4) | W'(nibble_in);
                if (digit_count != CNT_FULL)
                    digit_count <= digit_count + 1'b1;
            end
            if (state == HOLD && word_ready) begin
                word_valid <= 1'b0;
                state      <= ENTRY;
            end
        end
    end

endmodule
